// File: rtl/bus_arbitration_unit_if.sv
// Request/grant signal bundle between the request queue, bus ports and the arbiter.
// The arbiter sits on the slave modport; queue and ports drive the master side.
interface bus_arbitration_unit_if;
  logic [3:0] sender;
  logic [3:0] dest;
  logic       req_ready;
  logic       pull;
  logic relIE, relIO, relDEr, relDEw, relDOr, relDOw, relB0, relB1, relB2, relB3, relDMA;
  logic grantIE, grantIO, grantDEr, grantDEw, grantDOr, grantDOw;
  logic grantB0, grantB1, grantB2, grantB3, grantDMA;
  logic recvIE, recvIO, recvDE, recvDO, recvB0, recvB1, recvB2, recvB3, recvDMA;
  // Debug view of the arbiter: 1 = BUSY, plus latched owner/receiver IDs.
  logic       dbg_state;
  logic [3:0] dbg_owner;
  logic [3:0] dbg_receiver;

  modport master (
    output sender, dest, req_ready,
    output relIE, relIO, relDEr, relDEw, relDOr, relDOw, relB0, relB1, relB2, relB3, relDMA,
    input  pull,
    input  grantIE, grantIO, grantDEr, grantDEw, grantDOr, grantDOw,
    input  grantB0, grantB1, grantB2, grantB3, grantDMA,
    input  recvIE, recvIO, recvDE, recvDO, recvB0, recvB1, recvB2, recvB3, recvDMA,
    input  dbg_state, dbg_owner, dbg_receiver
  );

  modport slave (
    input  sender, dest, req_ready,
    input  relIE, relIO, relDEr, relDEw, relDOr, relDOw, relB0, relB1, relB2, relB3, relDMA,
    output pull,
    output grantIE, grantIO, grantDEr, grantDEw, grantDOr, grantDOw,
    output grantB0, grantB1, grantB2, grantB3, grantDMA,
    output recvIE, recvIO, recvDE, recvDO, recvB0, recvB1, recvB2, recvB3, recvDMA,
    output dbg_state, dbg_owner, dbg_receiver
  );
endinterface

// File: rtl/bus_arbitration_unit.sv
// Single-bus arbiter: pops one {sender,dest} request, grants the sender and flags the
// receiver, and holds that connection until the owning sender raises its release.
// Handshake: pull is high (combinational) in IDLE whenever req_ready is high; the
// request presented in that cycle is consumed at the next rising edge.
module bus_arbitration_unit (
  input  logic                  clk,
  input  logic                  clr,
  bus_arbitration_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      r_state;
  logic [3:0]  r_owner;
  logic [3:0]  r_receiver;
  logic [10:0] r_grant;
  logic [8:0]  r_recv;

  logic [10:0] w_rel;
  logic [10:0] w_grant_oh;
  logic [8:0]  w_recv_oh;
  logic        w_pull;
  logic        w_owner_rel;

  // Grant bits: IE,IO,DEr,DEw,DOr,DOw,B0,B1,B2,B3,DMA; zero for invalid sender codes.
  function automatic logic [10:0] grant_onehot(input logic [3:0] id);
    logic [10:0] oh;
    oh = '0;
    case (id)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: oh = 11'd1 << id;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC:       oh = 11'd1 << (id - 4'd2);
      default:                            oh = '0;
    endcase
    return oh;
  endfunction

  // Receiver bits: IE,IO,DE,DO,B0,B1,B2,B3,DMA; DE/DO each cover two codes.
  function automatic logic [8:0] recv_onehot(input logic [3:0] id);
    logic [8:0] oh;
    oh = '0;
    case (id)
      4'h0:                         oh = 9'd1;
      4'h1:                         oh = 9'd2;
      4'h2, 4'h3:                   oh = 9'd4;
      4'h4, 4'h5:                   oh = 9'd8;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC: oh = 9'd1 << (id - 4'd4);
      default:                      oh = '0;
    endcase
    return oh;
  endfunction

  assign w_rel = {bus.relDMA, bus.relB3, bus.relB2, bus.relB1, bus.relB0,
                  bus.relDOw, bus.relDOr, bus.relDEw, bus.relDEr, bus.relIO, bus.relIE};

  assign w_grant_oh  = grant_onehot(bus.sender);
  assign w_recv_oh   = recv_onehot(bus.dest);
  assign w_pull      = clr & (r_state == IDLE) & bus.req_ready;
  assign w_owner_rel = |(w_rel & grant_onehot(r_owner));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_receiver <= '0;
      r_grant    <= '0;
      r_recv     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Requests with an unmapped ID are popped and silently dropped.
          if (w_pull && (|w_grant_oh) && (|w_recv_oh)) begin
            r_state    <= BUSY;
            r_owner    <= bus.sender;
            r_receiver <= bus.dest;
            r_grant    <= w_grant_oh;
            r_recv     <= w_recv_oh;
          end
        end
        BUSY: begin
          if (w_owner_rel) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_receiver <= '0;
            r_grant    <= '0;
            r_recv     <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pull = w_pull;
  assign {bus.grantDMA, bus.grantB3, bus.grantB2, bus.grantB1, bus.grantB0,
          bus.grantDOw, bus.grantDOr, bus.grantDEw, bus.grantDEr, bus.grantIO,
          bus.grantIE} = r_grant;
  assign {bus.recvDMA, bus.recvB3, bus.recvB2, bus.recvB1, bus.recvB0,
          bus.recvDO, bus.recvDE, bus.recvIO, bus.recvIE} = r_recv;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_owner    = r_owner;
  assign bus.dbg_receiver = r_receiver;

endmodule

// File: tb/tb_bus_arbitration_unit.sv
// Bench for bus_arbitration_unit: directed scenarios then random traffic, all checked
// against a transaction-level model (owner/receiver codes mapped through ID tables).
module tb_bus_arbitration_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bus_arbitration_unit_if bif();

  bus_arbitration_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bif)
  );

  logic [3:0]  snd;
  logic [3:0]  dst;
  logic        rr;
  logic [10:0] rel_v;

  assign bif.sender    = snd;
  assign bif.dest      = dst;
  assign bif.req_ready = rr;
  assign {bif.relDMA, bif.relB3, bif.relB2, bif.relB1, bif.relB0, bif.relDOw,
          bif.relDOr, bif.relDEw, bif.relDEr, bif.relIO, bif.relIE} = rel_v;

  wire [10:0] grant_obs = {bif.grantDMA, bif.grantB3, bif.grantB2, bif.grantB1, bif.grantB0,
                           bif.grantDOw, bif.grantDOr, bif.grantDEw, bif.grantDEr,
                           bif.grantIO, bif.grantIE};
  wire [8:0]  recv_obs  = {bif.recvDMA, bif.recvB3, bif.recvB2, bif.recvB1, bif.recvB0,
                           bif.recvDO, bif.recvDE, bif.recvIO, bif.recvIE};

  // ---------------- reference model ----------------
  // Position of each ID code in the grant / receiver output lists (-1 = invalid code).
  int g_pos [16] = '{0, 1, 2, 3, 4, 5, -1, -1, 6, 7, 8, 9, 10, -1, -1, -1};
  int r_pos [16] = '{0, 1, 2, 2, 3, 3, -1, -1, 4, 5, 6, 7, 8, -1, -1, -1};

  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_recv  = 0;

  localparam int EW = 29;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] model_word();
    logic [10:0] g;
    logic [8:0]  r;
    logic [3:0]  o;
    logic [3:0]  d;
    g = '0;
    r = '0;
    o = '0;
    d = '0;
    if (m_busy) begin
      g[g_pos[m_owner]] = 1'b1;
      r[r_pos[m_recv]]  = 1'b1;
      o = 4'(m_owner);
      d = 4'(m_recv);
    end
    return {m_busy, o, d, r, g};
  endfunction

  // Transaction rules applied at each rising edge.
  task automatic model_edge();
    if (!clr) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (rr && g_pos[snd] >= 0 && r_pos[dst] >= 0) begin
        m_busy  = 1'b1;
        m_owner = int'(snd);
        m_recv  = int'(dst);
      end
    end else if (rel_v[g_pos[m_owner]]) begin
      m_busy = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at the falling edge, check 1 time unit later, model at rising edge.
  task automatic step(input logic c, input logic r, input logic [3:0] s,
                      input logic [3:0] d, input logic [10:0] rl);
    logic [EW-1:0] e;
    @(negedge clk);
    clr   = c;
    rr    = r;
    snd   = s;
    dst   = d;
    rel_v = rl;
    if (!c) begin
      m_busy = 1'b0;
      exp_q.delete();
      exp_q.push_back(model_word());
    end
    #1;
    chk("pull", 32'(bif.pull), 32'(c & ~m_busy & r));
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("grant",    32'(grant_obs),        32'(e[10:0]));
      chk("recv",     32'(recv_obs),         32'(e[19:11]));
      chk("state",    32'(bif.dbg_state),    32'(e[28]));
      chk("owner",    32'(bif.dbg_owner),    32'(e[27:24]));
      chk("receiver", 32'(bif.dbg_receiver), 32'(e[23:20]));
    end
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_word());
  endtask

  localparam logic [10:0] REL_IE  = 11'h001;
  localparam logic [10:0] REL_DMA = 11'h400;

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] rl;
    clr   = 1'b0;
    rr    = 1'b1;
    snd   = 4'h0;
    dst   = 4'hC;
    rel_v = '0;
    exp_q.push_back(model_word());

    // Reset held with a request waiting, then released.
    step(1'b0, 1'b1, 4'h0, 4'hC, '0);
    step(1'b0, 1'b1, 4'h0, 4'hC, '0);
    step(1'b1, 1'b1, 4'h0, 4'hC, '0);
    // IE owns the bus; DMA request must wait.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'hC, 4'hB, '0);
    step(1'b1, 1'b1, 4'hC, 4'hB, REL_IE);
    step(1'b1, 1'b1, 4'hC, 4'hB, '0);
    step(1'b1, 1'b1, 4'hC, 4'hB, '0);
    // Foreign release ignored, then owner release with no request pending.
    step(1'b1, 1'b0, 4'hC, 4'hB, REL_IE);
    step(1'b1, 1'b0, 4'hC, 4'hB, REL_DMA);
    step(1'b1, 1'b0, 4'hC, 4'hB, '0);
    step(1'b1, 1'b0, 4'hC, 4'hB, REL_DMA);
    // Invalid sender and invalid dest requests are dropped.
    step(1'b1, 1'b1, 4'h7, 4'h0, '0);
    step(1'b1, 1'b0, 4'h7, 4'h0, '0);
    step(1'b1, 1'b1, 4'h1, 4'hE, '0);
    step(1'b1, 1'b0, 4'h1, 4'hE, '0);
    // DMA to itself, with a release held over several edges.
    step(1'b1, 1'b1, 4'hC, 4'hC, '0);
    step(1'b1, 1'b0, 4'hC, 4'hC, '0);
    step(1'b1, 1'b0, 4'hC, 4'hC, REL_DMA);
    step(1'b1, 1'b1, 4'h3, 4'h5, REL_DMA);
    step(1'b1, 1'b1, 4'h3, 4'h5, REL_DMA);
    // Reset mid-transaction abandons it; request is re-popped only after reset.
    step(1'b0, 1'b1, 4'h3, 4'h5, '0);
    step(1'b0, 1'b1, 4'h3, 4'h5, '0);
    step(1'b1, 1'b1, 4'h9, 4'h2, '0);
    step(1'b1, 1'b0, 4'h9, 4'h2, 11'h080);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rl = '0;
      for (int b = 0; b < 11; b++) rl[b] = ($urandom_range(0, 7) == 0);
      if (m_busy && $urandom_range(0, 3) == 0) rl[g_pos[m_owner]] = 1'b1;
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbitration_unit.md
Name: bus_arbitration_unit

Overview:
- Single-bus arbitration unit for the shared interconnect. Requests arrive one at a time from a request queue as {sender, dest} with req_ready.
- The unit pops the request (pull), grants the bus to the sending port and flags the receiving port. It holds that connection until the sender releases it.
- Only one transaction owns the bus at any time.

Parameters:
- none (port map and ID encoding fixed)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- sender  in  4  sender ID of queue-head request
- dest  in  4  destination ID of queue-head request
- req_ready  in  1  queue head holds a valid request
- relIE, relIO, relDEr, relDEw, relDOr, relDOw, relB0, relB1, relB2, relB3, relDMA  in  1 each  sender releases bus
- pull  out  1  pop queue head (combinational)
- grantIE, grantIO, grantDEr, grantDEw, grantDOr, grantDOw, grantB0, grantB1, grantB2, grantB3, grantDMA  out  1 each  bus owned by that sender (registered)
- recvIE, recvIO, recvDE, recvDO, recvB0, recvB1, recvB2, recvB3, recvDMA  out  1 each  that port is current receiver (registered)

Behaviour:
- Sender ID map: 0x0 IE, 0x1 IO, 0x2 DEr, 0x3 DEw, 0x4 DOr, 0x5 DOw, 0x8 B0, 0x9 B1, 0xA B2, 0xB B3, 0xC DMA. Codes 0x6, 0x7, 0xD-0xF are invalid.
- Dest ID map: 0x0 IE, 0x1 IO, 0x2/0x3 DE, 0x4/0x5 DO, 0x8 B0, 0x9 B1, 0xA B2, 0xB B3, 0xC DMA. Same invalid codes.
- States: IDLE, BUSY. Registered owner ID (4 bits) and receiver ID.
- Reset (clr=0, asynchronous): state=IDLE; all grant* and recv* = 0; owner and receiver cleared.
- pull = clr & IDLE & req_ready. It is combinational and asserts for exactly one cycle per accepted request.
- IDLE, pull=1, both IDs valid:
  - At the next rising edge: BUSY; the matching grant bit = 1; the matching recv bit = 1. Latency is 1 cycle from pull.
- IDLE, pull=1, either ID invalid:
  - Request is popped and dropped. State stays IDLE; no grant or recv is asserted.
- BUSY:
  - grant and recv hold stable.
  - pull = 0 regardless of req_ready; the pending request waits.
- BUSY, rel of the current owner = 1 at a rising edge:
  - Next state IDLE; all grant* and recv* cleared at that edge.
  - The earliest next grant is one cycle later: at least one idle cycle between transactions.
- rel inputs of non-owners are ignored in all states. Any rel in IDLE is ignored.
- Multi-cycle rel: a rel held across the edge that returns to IDLE has no further effect.
- Exactly one grant and exactly one recv bit are high in BUSY (one-hot); all are zero in IDLE.
- sender==dest-port is legal: e.g. DMA→DMA asserts grantDMA and recvDMA.
- clr deasserted mid-transaction: outputs clear immediately (async) and the transaction is abandoned. The queue head is not re-popped until clr returns high and the unit is in IDLE.
- req_ready low in IDLE: pull=0; state holds.

Test Plan:
- Reset: clr=0 with req_ready=1 → pull=0, all grant/recv=0. Release clr → pull=1 that cycle.
- Basic grant: clr=1, req_ready=1, sender=0x0, dest=0xC → pull=1. Next edge grantIE=1, recvDMA=1, others 0; pull=0 afterwards.
- Queued request blocked: while IE owns the bus, present sender=0xC, dest=0xB, req_ready=1 for 5 cycles → pull=0, grant/recv unchanged.
- Release and re-grant: pulse relIE one cycle → at that edge all outputs 0. Next cycle pull=1. Following edge grantDMA=1, recvB3=1.
- Foreign release ignored: with DMA owning the bus, pulse relIE → no change. Deassert req_ready, then pulse relDMA → outputs clear; pull stays 0 and the unit stays IDLE.
- Invalid ID: sender=0x7, dest=0x0, req_ready=1 in IDLE → pull=1 for one cycle; no grant/recv; unit remains IDLE.
